// File: rtl/fp_div_bf16_pkg.sv
// rtl/fp_div_bf16_pkg.sv - shared bfloat16 constants, fflags indices and divider state type
package fp_div_bf16_pkg;

  localparam int BF16_EXP_W = 8;
  localparam int BF16_MAN_W = 7;
  localparam int BF16_BIAS  = 127;

  localparam logic [15:0] BF16_QNAN = 16'h7FC0;

  // Bit positions inside the 5-bit {NV, DZ, OF, UF, NX} flag vector
  localparam int FF_NV = 4;
  localparam int FF_DZ = 3;
  localparam int FF_OF = 2;
  localparam int FF_UF = 1;
  localparam int FF_NX = 0;

  localparam logic [3:0] DIV_LAST_ITER = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    RND  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/fp_div_bf16_round_pack.sv
// rtl/fp_div_bf16_round_pack.sv - normalize, round-to-nearest-even, range check and pack
module bf16_round_pack
  import fp_div_bf16_pkg::*;
(
  input  logic              sign,
  input  logic signed [9:0] e,
  input  logic [9:0]        q,
  input  logic              rem_nz,
  output logic [15:0]       result,
  output logic [4:0]        flags
);

  logic signed [9:0] e_adj;
  logic signed [9:0] e_rnd;
  logic [8:0]        sig;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [8:0]        mant_sum;
  logic [BF16_MAN_W-1:0] mant;

  always_comb begin
    e_adj  = e;
    sig    = q[9:1];
    sticky = q[0] | rem_nz;
    if (!q[9]) begin
      sig    = q[8:0];
      sticky = rem_nz;
      e_adj  = e - 10'sd1;
    end
    guard    = sig[0];
    round_up = guard & (sticky | sig[1]);
    mant_sum = {1'b0, sig[8:1]} + {8'd0, round_up};
    e_rnd    = e_adj;
    mant     = mant_sum[6:0];
    // Carry out of the hidden bit renormalizes to 1.0 x 2^(e+1)
    if (mant_sum[8]) begin
      e_rnd = e_adj + 10'sd1;
      mant  = mant_sum[7:1];
    end

    result = 16'h0000;
    flags  = 5'b00000;
    if (e_rnd >= 10'sd255) begin
      result        = {sign, 8'hFF, 7'h00};
      flags[FF_OF]  = 1'b1;
      flags[FF_NX]  = 1'b1;
    end else if (e_rnd <= 10'sd0) begin
      result        = {sign, 15'h0000};
      flags[FF_UF]  = 1'b1;
      flags[FF_NX]  = 1'b1;
    end else begin
      result        = {sign, e_rnd[7:0], mant};
      flags[FF_NX]  = guard | sticky;
    end
  end

endmodule

// File: rtl/fp_div_bf16.sv
// rtl/fp_div_bf16.sv - iterative restoring bfloat16 divider with valid/ready request and result
module fp_div_bf16
  import fp_div_bf16_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] operand_a_i,
  input  logic [15:0] operand_b_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o,
  output logic [4:0]  fflags_o
);

  div_state_e        state;
  logic [3:0]        cnt;
  logic              sign;
  logic signed [9:0] e;
  logic [7:0]        mb;
  logic [8:0]        rem;
  logic [9:0]        q;

  logic                  sa, sb;
  logic [BF16_EXP_W-1:0] ea, eb;
  logic [BF16_MAN_W-1:0] fa, fb;
  logic                  a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic signed [9:0]     e_init;
  logic                  special;
  logic [15:0]           sp_result;
  logic [4:0]            sp_flags;
  logic                  rem_ge;
  logic [8:0]            rem_sub;
  logic [8:0]            rem_next;
  logic [15:0]           rp_result;
  logic [4:0]            rp_flags;
  logic                  unused_low;

  assign sa = operand_a_i[31];
  assign ea = operand_a_i[30:23];
  assign fa = operand_a_i[22:16];
  assign sb = operand_b_i[15];
  assign eb = operand_b_i[14:7];
  assign fb = operand_b_i[6:0];
  assign unused_low = ^operand_a_i[15:0];

  // Subnormals are flushed: a zero exponent is treated as zero whatever the mantissa
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);
  assign a_inf  = (ea == 8'hFF) && (fa == 7'h00);
  assign b_inf  = (eb == 8'hFF) && (fb == 7'h00);
  assign a_nan  = (ea == 8'hFF) && (fa != 7'h00);
  assign b_nan  = (eb == 8'hFF) && (fb != 7'h00);

  assign e_init = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'(BF16_BIAS);

  always_comb begin
    special   = 1'b1;
    sp_result = 16'h0000;
    sp_flags  = 5'b00000;
    if (a_nan || b_nan) begin
      sp_result       = BF16_QNAN;
      sp_flags[FF_NV] = (a_nan && !fa[6]) || (b_nan && !fb[6]);
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      sp_result       = BF16_QNAN;
      sp_flags[FF_NV] = 1'b1;
    end else if (a_inf) begin
      sp_result = {sa ^ sb, 8'hFF, 7'h00};
    end else if (b_zero) begin
      sp_result       = {sa ^ sb, 8'hFF, 7'h00};
      sp_flags[FF_DZ] = 1'b1;
    end else if (a_zero || b_inf) begin
      sp_result = {sa ^ sb, 15'h0000};
    end else begin
      special = 1'b0;
    end
  end

  // Partial remainder stays below 2*mb, so 9 bits hold it across the shift
  assign rem_ge   = (rem >= {1'b0, mb});
  assign rem_sub  = rem_ge ? (rem - {1'b0, mb}) : rem;
  assign rem_next = rem_sub << 1;

  bf16_round_pack u_round_pack (
    .sign   (sign),
    .e      (e),
    .q      (q),
    .rem_nz (rem != 9'd0),
    .result (rp_result),
    .flags  (rp_flags)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      sign     <= 1'b0;
      e        <= 10'sd0;
      mb       <= 8'd0;
      rem      <= 9'd0;
      q        <= 10'd0;
      result_o <= 32'd0;
      fflags_o <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            sign <= sa ^ sb;
            e    <= e_init;
            mb   <= {1'b1, fb};
            rem  <= {2'b01, fa};
            q    <= 10'd0;
            cnt  <= 4'd0;
            if (special) begin
              result_o <= {sp_result, 16'h0000};
              fflags_o <= sp_flags;
              state    <= DONE;
            end else begin
              state <= DIV;
            end
          end
        end
        DIV: begin
          rem <= rem_next;
          q   <= {q[8:0], rem_ge};
          if (cnt == DIV_LAST_ITER) begin
            state <= RND;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RND: begin
          result_o <= {rp_result, 16'h0000};
          fflags_o <= rp_flags;
          state    <= DONE;
        end
        DONE: begin
          if (ready_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready_o = (state == IDLE);
  assign valid_o = (state == DONE);

endmodule

// File: doc/fp_div_bf16.md
# fp_div_bf16

Iterative bfloat16 divider providing the division path of the FP unit, the inverse of the existing bfloat16 multiply. It uses the same operand/result packing as the combinational FPU: operand A in the upper half of a 32-bit word, operand B as a 16-bit value, and the result in the upper half with zeros below. Requests and results each use a valid/ready handshake, so the EX stage can stall on the multi-cycle result. Division is restoring, one quotient bit per cycle, with round-to-nearest-even and RISC-V fflags.

## Interface
- No parameters; bfloat16 format is fixed: 1 sign, 8 exponent, 7 mantissa, bias 127.
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- valid_i  in  1  request valid
- ready_o  out  1  request accepted when valid_i && ready_o
- operand_a_i  in  32  dividend; bf16 in [31:16], [15:0] ignored
- operand_b_i  in  16  divisor, bf16
- valid_o  out  1  result valid, held until accepted
- ready_i  in  1  result consumed when valid_o && ready_i
- result_o  out  32  quotient in [31:16], [15:0] = 0
- fflags_o  out  5  {NV, DZ, OF, UF, NX}, valid with valid_o

## Operation
- States:
  - IDLE: ready_o=1.
  - DIV: 10 iterations.
  - RND: normalize, round, pack.
  - DONE: valid_o=1.
- Operands are latched on accept.
- Sign = sa ^ sb. Exponent e = ea - eb + 127, held as 10-bit signed.
- Subnormal inputs are flushed to signed zero before classification. Subnormals are never produced.
- Special cases are decided at accept: IDLE -> DONE, skipping DIV and RND. In precedence order:
  - Any NaN input -> 0x7FC0. NV is set only for a signalling NaN (mantissa bit 6 = 0).
  - 0/0 or inf/inf -> 0x7FC0, NV.
  - inf/finite -> signed inf.
  - Finite nonzero / 0 -> signed inf, DZ.
  - 0/finite, or finite/inf -> signed zero.
- Normal path:
  - Significands are ma = {1, fa} and mb = {1, fb}; the remainder register starts at ma.
  - Each DIV cycle: if rem >= mb, set the quotient bit and subtract mb; then shift rem left by 1. Quotient bits are produced MSB first into q[9:0].
  - Normalization: if q[9]=1, take {hidden, mant[6:0], guard} = q[9:1], and sticky = q[0] | (rem != 0). Otherwise take q[8:0], sticky = (rem != 0), and decrement e.
  - Rounding is RNE: round up if guard && (sticky || mant[0]). A mantissa carry-out increments e and clears the mantissa.
  - Overflow (e >= 255): signed inf, OF and NX.
  - Underflow (e <= 0): signed zero, UF and NX.
  - NX = guard | sticky on the in-range path.

## Timing
- Reset state: IDLE, ready_o=1, valid_o=0, result_o=0, fflags_o=0. Internal registers are cleared.
- Accept at edge T:
  - Normal path: DIV during cycles T+1..T+10, RND at T+11, valid_o=1 from T+12.
  - Special-case path: valid_o=1 from T+1.
- DONE holds result_o and fflags_o stable until ready_i=1. The next cycle is IDLE.
- ready_o=0 in DIV, RND and DONE. There is no overlap of transactions; a new accept happens at the earliest one cycle after the output handshake.
- valid_i while busy is ignored, with no capture.
- rst_i in any state returns to reset values on the next edge. A partially computed result is discarded and never presented.
- result_o and fflags_o are registered outputs. They are don't-care outside DONE but are driven 0 after reset.

## Structure
- The following go in the shared package next to the existing FP ALU types:
  - Constants BF16_QNAN = 16'h7FC0, BF16_BIAS = 127, BF16 field widths.
  - fflags bit index constants.
  - State enum div_state_e {IDLE, DIV, RND, DONE}.
- One sub-module, bf16_round_pack: a combinational block performing normalize, RNE, overflow/underflow and packing. Its inputs are sign, e, q, rem_nz; its outputs are result and flags.
- The iteration counter is 4-bit and counts 0..9.

## Test plan
- Exact result: 0x40C0 / 0x4000 (6/2) -> result_o=0x4040_0000, fflags=0, valid_o 12 cycles after accept.
- Rounding: 0x3F80 / 0x4040 (1/3) -> 0x3EAB_0000, NX set, fflags=0x01.
- Special cases, each with latency 1:
  - 0x3F80 / 0x0000 -> 0x7F80_0000, DZ (fflags=0x08).
  - 0x0000 / 0x0000 -> 0x7FC0_0000, NV (fflags=0x10).
  - 0xFF80 / 0x4000 -> 0xFF80_0000, fflags=0.
- Overflow: 0x7F00 / 0x3F00 -> 0x7F80_0000, fflags=0x05.
- Underflow: 0x0080 / 0x4000 -> 0x0000_0000, fflags=0x03.
- Handshake and reset:
  - Hold ready_i=0 for 5 cycles in DONE: output stays stable, and ready_o stays 0 throughout.
  - Pulse valid_i while in DIV: no second capture.
  - Assert rst_i at iteration 5: next cycle ready_o=1, valid_o=0, and the following transaction is correct.
